// File: rtl/audio_pkg.sv
// audio_pkg
//   Shared definitions for the audio sample schedulers: sample and channel
//   widths, the stereo field positions inside a 32-bit sample, the width of
//   a source index and the scheduler state encoding.
package audio_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int CH_W      = 16;

  // Right channel in the upper half, left channel in the lower half.
  localparam int R_MSB     = 31;
  localparam int R_LSB     = 16;
  localparam int L_MSB     = 15;
  localparam int L_LSB     = 0;

  localparam int SRC_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin priority select. The search starts at the
//   requester just after ptr and wraps modulo NUM_SRC, so the requester that
//   was granted last has the lowest priority.
// Ports:
//   req        in   NUM_SRC    request vector
//   ptr        in   SRC_IDX_W  index of the previous grant
//   grant      out  NUM_SRC    one-hot grant (all zero when nothing requests)
//   grant_idx  out  SRC_IDX_W  index of the granted requester
//   any        out  1          at least one request present
module rr_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [NUM_SRC-1:0]   grant,
  output logic [SRC_IDX_W-1:0] grant_idx,
  output logic                 any
);

  // Each requester gets a rank equal to its distance past ptr; the lowest
  // ranked active requester wins. ptr never exceeds NUM_SRC-1, so the
  // dividend stays non-negative.
  always_comb begin
    int rank;
    int best;
    rank      = 0;
    best      = NUM_SRC;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      rank = (j + NUM_SRC - 1 - int'(ptr)) % NUM_SRC;
      if (req[j] && (rank < best)) begin
        best      = rank;
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = SRC_IDX_W'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_stream_sched.sv
// audio_stream_sched
//   Round-robin scheduler sharing one audio_output sample FIFO among NUM_SRC
//   producers. A sample is accepted from the granted source, presented on
//   audio_data, and written by flipping audio_valid_toggle one cycle later.
//   After each flip the scheduler waits GUARD_CYCLES cycles because
//   audio_full reflects a write only several cycles after the toggle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enable              scheduler run enable
//   src_mask            per-source enable (0 = never granted)
//   src_data            source i sample at [32*i+31:32*i], R=[31:16] L=[15:0]
//   src_valid           source i has a sample
//   src_ready           one-hot accept, combinational in the grant cycle
//   audio_data          sample to audio_output
//   audio_valid_toggle  write strobe to audio_output (each flip = one write)
//   audio_full          full flag from audio_output, only looked at in ARB
//   sent_count          samples handed over, wrapping
//   last_src            index of the most recent grant
module audio_stream_sched
  import audio_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_SRC-1:0]           src_mask,
  input  logic [NUM_SRC*SAMPLE_W-1:0]  src_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [SAMPLE_W-1:0]          audio_data,
  output logic                         audio_valid_toggle,
  input  logic                         audio_full,
  output logic [31:0]                  sent_count,
  output logic [SRC_IDX_W-1:0]         last_src
);

  localparam int GW = $clog2(GUARD_CYCLES);

  sched_state_t         state;
  sched_state_t         next_state;
  logic [SRC_IDX_W-1:0] ptr;
  logic [GW-1:0]        guard_cnt;
  logic [NUM_SRC-1:0]   req;
  logic [NUM_SRC-1:0]   arb_grant;
  logic [SRC_IDX_W-1:0] arb_idx;
  logic                 arb_any;
  logic                 take;
  logic [SAMPLE_W-1:0]  sel_sample;
  logic [CH_W-1:0]      sel_r;
  logic [CH_W-1:0]      sel_l;

  assign req = src_valid & src_mask;

  rr_arbiter #(
    .NUM_SRC   (NUM_SRC)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // One-hot mux of the granted source's sample.
  always_comb begin
    sel_sample = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (arb_grant[j]) sel_sample = src_data[SAMPLE_W*j +: SAMPLE_W];
    end
  end

  assign sel_r = sel_sample[R_MSB:R_LSB];
  assign sel_l = sel_sample[L_MSB:L_LSB];

  always_comb begin
    next_state = state;
    src_ready  = '0;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) next_state = ARB;
      end
      ARB: begin
        if (!enable) begin
          next_state = IDLE;
        end else if (!audio_full && arb_any) begin
          take       = 1'b1;
          src_ready  = arb_grant;
          next_state = SEND;
        end
      end
      SEND: begin
        next_state = GUARD;
      end
      GUARD: begin
        // enable is only re-examined once the guard window has elapsed, so a
        // transaction in flight always completes.
        if (guard_cnt == '0) next_state = enable ? ARB : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // audio_data only moves on a grant edge, so it is stable from one cycle
  // before each toggle flip until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_data         <= '0;
      audio_valid_toggle <= 1'b0;
      sent_count         <= '0;
      last_src           <= '0;
      ptr                <= SRC_IDX_W'(NUM_SRC - 1);
      guard_cnt          <= '0;
    end else begin
      if (take) begin
        audio_data <= {sel_r, sel_l};
        ptr        <= arb_idx;
        last_src   <= arb_idx;
      end
      if (state == SEND) begin
        audio_valid_toggle <= ~audio_valid_toggle;
        sent_count         <= sent_count + 32'd1;
        guard_cnt          <= GW'(GUARD_CYCLES - 1);
      end else if ((state == GUARD) && (guard_cnt != '0)) begin
        guard_cnt <= guard_cnt - GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_stream_sched.sv
module tb_audio_stream_sched;
  import audio_pkg::*;

  localparam int N = 4;
  localparam int G = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   src_mask;
  logic [N*32-1:0] src_data;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [31:0]    audio_data;
  logic           audio_valid_toggle;
  logic           audio_full;
  logic [31:0]    sent_count;
  logic [2:0]     last_src;

  always #5 clk = ~clk;

  audio_stream_sched #(
    .NUM_SRC            (N),
    .GUARD_CYCLES       (G)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .src_mask           (src_mask),
    .src_data           (src_data),
    .src_valid          (src_valid),
    .src_ready          (src_ready),
    .audio_data         (audio_data),
    .audio_valid_toggle (audio_valid_toggle),
    .audio_full         (audio_full),
    .sent_count         (sent_count),
    .last_src           (last_src)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: "listening" means a grant may happen this
  // cycle; after a grant the scheduler is busy for G+1 cycles, the write
  // (toggle flip + count) landing on the edge after the grant.
  bit          m_listen;
  int          m_busy;
  int          m_ptr;
  int          m_last;
  logic [31:0] m_data;
  logic [31:0] m_count;
  logic        m_tog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int from, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int s;
      s = (from + k) % N;
      if (req[s]) return s;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    m_listen = 1'b0;
    m_busy   = 0;
    m_ptr    = N - 1;
    m_last   = 0;
    m_data   = '0;
    m_count  = '0;
    m_tog    = 1'b0;
  endtask

  task automatic model_cycle();
    logic [N-1:0] req;
    logic [N-1:0] exp_ready;
    int g;
    req       = src_valid & src_mask;
    exp_ready = '0;
    g         = -1;
    if (m_listen && enable && !audio_full) g = rr_pick(m_ptr, req);
    if (g >= 0) exp_ready[g] = 1'b1;
    check("src_ready",  32'(src_ready), 32'(exp_ready));
    check("audio_data", audio_data, m_data);
    check("toggle",     32'(audio_valid_toggle), 32'(m_tog));
    check("sent_count", sent_count, m_count);
    check("last_src",   32'(last_src), 32'(m_last));
    if (reset) begin
      model_reset();
    end else if (g >= 0) begin
      m_data   = src_data[32*g +: 32];
      m_ptr    = g;
      m_last   = g;
      m_busy   = G + 1;
      m_listen = 1'b0;
    end else if (m_busy > 0) begin
      if (m_busy == G + 1) begin
        m_tog   = ~m_tog;
        m_count = m_count + 32'd1;
      end
      m_busy--;
      if (m_busy == 0) m_listen = enable;
    end else if (!m_listen) begin
      m_listen = enable;
    end else if (!enable) begin
      m_listen = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int j = 0; j < N; j++) src_data[32*j +: 32] = $urandom;
  endtask

  initial begin
    int seq[$];
    int gcyc[$];
    int idx;

    reset = 1'b1; enable = 1'b0; src_mask = 4'hF; src_valid = '0;
    src_data = '0; audio_full = 1'b0;
    @(posedge clk); #1;
    model_reset();
    tick();

    // Single transfer from source 0.
    reset = 1'b0; enable = 1'b1; src_valid = 4'b0001;
    src_data[31:0] = 32'h1234_ABCD;
    #1;
    check("t1_rst_toggle", 32'(audio_valid_toggle), 32'd0);
    check("t1_rst_data", audio_data, 32'd0);
    check("t1_rst_ready", 32'(src_ready), 32'd0);
    tick();
    #1 check("t1_ready", 32'(src_ready), 32'b0001);
    tick();
    src_valid = '0;
    #1;
    check("t1_data", audio_data, 32'h1234_ABCD);
    check("t1_tog_pre", 32'(audio_valid_toggle), 32'd0);
    check("t1_ready_off", 32'(src_ready), 32'd0);
    tick();
    #1;
    check("t1_toggle", 32'(audio_valid_toggle), 32'd1);
    check("t1_count", sent_count, 32'd1);
    repeat (6) tick();

    // Fairness with all sources valid, from a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0;
    enable = 1'b1; src_valid = 4'hF; src_mask = 4'hF;
    for (int c = 0; c < 200 && seq.size() < 12; c++) begin
      tick();
      rand_data();
      #1;
      if (src_ready != '0) begin
        seq.push_back(onehot_idx(src_ready));
        gcyc.push_back(c);
      end
    end
    check("t2_grants", 32'(seq.size()), 32'd12);
    for (int i = 0; i < seq.size(); i++) check("t2_order", 32'(seq[i]), 32'(i % 4));
    for (int i = 1; i < gcyc.size(); i++) check("t2_period", 32'(gcyc[i] - gcyc[i-1]), 32'd6);
    tick(); tick();
    #1 check("t2_count", sent_count, 32'd12);
    enable = 1'b0;
    repeat (8) tick();

    // Back-pressure: full held high, then released.
    enable = 1'b1; audio_full = 1'b1; src_valid = 4'hF;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      check("t3_no_ready", 32'(src_ready), 32'd0);
      check("t3_toggle_static", 32'(audio_valid_toggle), 32'd0);
    end
    audio_full = 1'b0;
    #1 check("t3_resume", 32'(src_ready), 32'b0001);
    tick();
    enable = 1'b0;
    repeat (8) tick();

    // Masked sources 0 and 2 never granted.
    seq.delete();
    src_mask = 4'b1010; src_valid = 4'hF; enable = 1'b1;
    for (int c = 0; c < 100 && seq.size() < 4; c++) begin
      tick();
      #1;
      check("t4_masked", 32'(src_ready & 4'b0101), 32'd0);
      if (src_ready != '0) seq.push_back(onehot_idx(src_ready));
    end
    check("t4_grants", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++) check("t4_order", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    tick();
    enable = 1'b0;
    repeat (8) tick();

    // Enable dropped during SEND: the write still completes.
    src_mask = 4'hF; src_valid = 4'b0001; enable = 1'b1;
    idx = -1;
    for (int c = 0; c < 20 && idx < 0; c++) begin
      tick();
      #1;
      if (src_ready != '0) idx = onehot_idx(src_ready);
    end
    check("t5_grant", 32'(idx), 32'd0);
    tick();
    enable = 1'b0; src_valid = 4'hF;
    tick();
    #1;
    check("t5_toggle", 32'(audio_valid_toggle), 32'd0);
    check("t5_count", sent_count, 32'd18);
    repeat (3) tick();
    #1 check("t5_not_idle_yet", 32'(dut.state == IDLE), 32'd0);
    tick();
    #1 check("t5_idle", 32'(dut.state), 32'(IDLE));
    for (int c = 0; c < 10; c++) begin
      tick();
      #1 check("t5_quiet", 32'(src_ready), 32'd0);
    end

    // sent_count wrap.
    force dut.sent_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick();
    release dut.sent_count;
    tick();
    enable = 1'b1; src_valid = 4'b0001;
    idx = -1;
    for (int c = 0; c < 20 && idx < 0; c++) begin
      tick();
      #1;
      if (src_ready != '0) idx = onehot_idx(src_ready);
    end
    check("t6_grant", 32'(idx), 32'd0);
    tick(); tick();
    #1 check("t6_wrap", sent_count, 32'd0);

    // Reset in the middle of the guard window.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_rst_toggle", 32'(audio_valid_toggle), 32'd0);
    check("t6_rst_data", audio_data, 32'd0);
    check("t6_rst_state", 32'(dut.state), 32'(IDLE));

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      src_mask   = 4'($urandom);
      src_valid  = 4'($urandom);
      audio_full = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      rand_data();
      tick();
    end
    reset = 1'b0; enable = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
